draw_sequencer: RTL and testbench

Controller that sequences the screen-fill engine and the circle engine for one drawing request, and owns the single shared VGA adapter plot bus (x, y, colour, plot). It accepts a start/done request from the top level with latched circle configuration. It runs fill then circle using the lab start/done handshake, and muxes the granted engine's plot bus onto the adapter. It sits in the top-level module between the engines and the vga_adapter instance.

---
 rtl/draw_pkg.sv | 26 ++
 rtl/vga_bus_mux.sv | 90 +++++++++
 rtl/draw_sequencer.sv | 172 +++++++++++++++++
 tb/tb_draw_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared constants for the draw sequencer: screen geometry, default widths,
// FSM state encodings and the bus grant type.
package draw_pkg;

    localparam int unsigned SCREEN_W     = 160;
    localparam int unsigned SCREEN_H     = 120;
    localparam int unsigned DEF_X_W      = 8;
    localparam int unsigned DEF_Y_W      = 7;
    localparam int unsigned DEF_COLOUR_W = 3;
    localparam int unsigned STATE_W      = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_FILL     = 3'd1;
    localparam state_t ST_FILL_REL = 3'd2;
    localparam state_t ST_CIRCLE   = 3'd3;
    localparam state_t ST_DONE     = 3'd4;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_FILL = 2'd1,
        GRANT_CIRC = 2'd2
    } grant_e;

endpackage

// File: rtl/vga_bus_mux.sv
// Registered 2:1 plot-bus mux onto the VGA adapter. Ungranted engines are
// blocked and flagged through a sticky conflict bit.
module vga_bus_mux
    import draw_pkg::*;
#(
    parameter int unsigned X_W      = DEF_X_W,
    parameter int unsigned Y_W      = DEF_Y_W,
    parameter int unsigned COLOUR_W = DEF_COLOUR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  grant_e              i_grant,
    input  logic [X_W-1:0]      i_fill_x,
    input  logic [Y_W-1:0]      i_fill_y,
    input  logic [COLOUR_W-1:0] i_fill_colour,
    input  logic                i_fill_plot,
    input  logic [X_W-1:0]      i_circ_x,
    input  logic [Y_W-1:0]      i_circ_y,
    input  logic [COLOUR_W-1:0] i_circ_colour,
    input  logic                i_circ_plot,
    output logic [X_W-1:0]      o_x,
    output logic [Y_W-1:0]      o_y,
    output logic [COLOUR_W-1:0] o_colour,
    output logic                o_plot,
    output logic                o_conflict
);

    logic [X_W-1:0]      w_x;
    logic [Y_W-1:0]      w_y;
    logic [COLOUR_W-1:0] w_colour;
    logic                w_plot;
    logic                w_conflict_hit;

    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic                r_conflict;

    // Select the granted engine; anything else drives an all-zero bus.
    always_comb begin
        w_x      = '0;
        w_y      = '0;
        w_colour = '0;
        w_plot   = 1'b0;
        case (i_grant)
            GRANT_FILL: begin
                w_x      = i_fill_x;
                w_y      = i_fill_y;
                w_colour = i_fill_colour;
                w_plot   = i_fill_plot;
            end
            GRANT_CIRC: begin
                w_x      = i_circ_x;
                w_y      = i_circ_y;
                w_colour = i_circ_colour;
                w_plot   = i_circ_plot;
            end
            default: ;
        endcase
    end

    assign w_conflict_hit = (i_fill_plot && (i_grant != GRANT_FILL))
                         || (i_circ_plot && (i_grant != GRANT_CIRC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_x      <= w_x;
            r_y      <= w_y;
            r_colour <= w_colour;
            r_plot   <= w_plot;
            if (w_conflict_hit) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_colour   = r_colour;
    assign o_plot     = r_plot;
    assign o_conflict = r_conflict;

endmodule

// File: rtl/draw_sequencer.sv
// Sequences the fill and circle engines for one drawing request and owns the
// shared VGA plot bus.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned X_W         = DEF_X_W,
    parameter int unsigned Y_W         = DEF_Y_W,
    parameter int unsigned COLOUR_W    = DEF_COLOUR_W,
    parameter int unsigned CLEAR_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                done,
    output logic                busy,
    input  logic [X_W-1:0]      cfg_cx,
    input  logic [Y_W-1:0]      cfg_cy,
    input  logic [X_W-1:0]      cfg_r,
    input  logic [COLOUR_W-1:0] cfg_colour,
    output logic                fill_start,
    input  logic                fill_done,
    input  logic [X_W-1:0]      fill_x,
    input  logic [Y_W-1:0]      fill_y,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic                fill_plot,
    output logic                circ_start,
    input  logic                circ_done,
    output logic [X_W-1:0]      circ_cx,
    output logic [Y_W-1:0]      circ_cy,
    output logic [X_W-1:0]      circ_r,
    output logic [COLOUR_W-1:0] circ_colour,
    input  logic [X_W-1:0]      circ_x,
    input  logic [Y_W-1:0]      circ_y,
    input  logic [COLOUR_W-1:0] circ_colour_px,
    input  logic                circ_plot,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                conflict
);

    state_t              r_state;
    state_t              w_state_nx;
    logic                w_latch;
    grant_e              w_grant;

    logic                r_fill_start;
    logic                r_circ_start;
    logic                r_done;
    logic                r_busy;
    logic [X_W-1:0]      r_cx;
    logic [Y_W-1:0]      r_cy;
    logic [X_W-1:0]      r_r;
    logic [COLOUR_W-1:0] r_colour;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_latch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_latch    = 1'b1;
                    w_state_nx = (CLEAR_FIRST != 0) ? ST_FILL : ST_CIRCLE;
                end
            end
            ST_FILL: begin
                if (fill_done) begin
                    w_state_nx = ST_FILL_REL;
                end
            end
            // Circle start waits for fill_done to fall so the engines never overlap.
            ST_FILL_REL: begin
                if (!fill_done) begin
                    w_state_nx = ST_CIRCLE;
                end
            end
            ST_CIRCLE: begin
                if (circ_done) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state so they track the entered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_start <= 1'b0;
            r_circ_start <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_fill_start <= (w_state_nx == ST_FILL);
            r_circ_start <= (w_state_nx == ST_CIRCLE);
            r_done       <= (w_state_nx == ST_DONE);
            r_busy       <= (w_state_nx == ST_FILL)
                         || (w_state_nx == ST_FILL_REL)
                         || (w_state_nx == ST_CIRCLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx     <= '0;
            r_cy     <= '0;
            r_r      <= '0;
            r_colour <= '0;
        end else if (w_latch) begin
            r_cx     <= cfg_cx;
            r_cy     <= cfg_cy;
            r_r      <= cfg_r;
            r_colour <= cfg_colour;
        end
    end

    always_comb begin
        w_grant = GRANT_NONE;
        if (w_state_nx == ST_FILL) begin
            w_grant = GRANT_FILL;
        end else if (w_state_nx == ST_CIRCLE) begin
            w_grant = GRANT_CIRC;
        end
    end

    vga_bus_mux #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOUR_W (COLOUR_W)
    ) u_mux (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_grant       (w_grant),
        .i_fill_x      (fill_x),
        .i_fill_y      (fill_y),
        .i_fill_colour (fill_colour),
        .i_fill_plot   (fill_plot),
        .i_circ_x      (circ_x),
        .i_circ_y      (circ_y),
        .i_circ_colour (circ_colour_px),
        .i_circ_plot   (circ_plot),
        .o_x           (vga_x),
        .o_y           (vga_y),
        .o_colour      (vga_colour),
        .o_plot        (vga_plot),
        .o_conflict    (conflict)
    );

    assign fill_start  = r_fill_start;
    assign circ_start  = r_circ_start;
    assign done        = r_done;
    assign busy        = r_busy;
    assign circ_cx     = r_cx;
    assign circ_cy     = r_cy;
    assign circ_r      = r_r;
    assign circ_colour = r_colour;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: a phase-level reference model checked every cycle,
// plus directed literal checks, on a CLEAR_FIRST=1 and a CLEAR_FIRST=0 instance.
module tb_draw_sequencer;

    localparam int P_IDLE = 0;
    localparam int P_FILL = 1;
    localparam int P_REL  = 2;
    localparam int P_CIRC = 3;
    localparam int P_DONE = 4;

    typedef struct {
        int         ph;
        logic       fs, cs, busy, done, conf, vp;
        logic [7:0] cx, r, vx;
        logic [6:0] cy, vy;
        logic [2:0] col, vc;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, start0 = 1'b0;
    logic [7:0] cfg_cx = '0, cfg_r = '0;
    logic [6:0] cfg_cy = '0;
    logic [2:0] cfg_colour = '0;
    logic       fill_done = 1'b0, fill_plot = 1'b0;
    logic [7:0] fill_x = '0;
    logic [6:0] fill_y = '0;
    logic [2:0] fill_colour = '0;
    logic       circ_done = 1'b0, circ_plot = 1'b0, circ_done0 = 1'b0;
    logic [7:0] circ_x = '0;
    logic [6:0] circ_y = '0;
    logic [2:0] circ_colour_px = '0;

    logic       done, busy, fill_start, circ_start, vga_plot, conflict;
    logic [7:0] circ_cx, circ_r, vga_x;
    logic [6:0] circ_cy, vga_y;
    logic [2:0] circ_colour, vga_colour;

    logic       done0, busy0, fill_start0, circ_start0, vga_plot0, conflict0;
    logic [7:0] circ_cx0, circ_r0, vga_x0;
    logic [6:0] circ_cy0, vga_y0;
    logic [2:0] circ_colour0, vga_colour0;

    int   n_err = 0;
    int   n_checks = 0;
    mdl_t m1, m0;

    always #5 clk = ~clk;

    draw_sequencer #(.X_W(8), .Y_W(7), .COLOUR_W(3), .CLEAR_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
        .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_r(cfg_r), .cfg_colour(cfg_colour),
        .fill_start(fill_start), .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
        .fill_colour(fill_colour), .fill_plot(fill_plot),
        .circ_start(circ_start), .circ_done(circ_done), .circ_cx(circ_cx), .circ_cy(circ_cy),
        .circ_r(circ_r), .circ_colour(circ_colour), .circ_x(circ_x), .circ_y(circ_y),
        .circ_colour_px(circ_colour_px), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .conflict(conflict)
    );

    draw_sequencer #(.X_W(8), .Y_W(7), .COLOUR_W(3), .CLEAR_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .done(done0), .busy(busy0),
        .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_r(cfg_r), .cfg_colour(cfg_colour),
        .fill_start(fill_start0), .fill_done(1'b0), .fill_x(8'd0), .fill_y(7'd0),
        .fill_colour(3'd0), .fill_plot(1'b0),
        .circ_start(circ_start0), .circ_done(circ_done0), .circ_cx(circ_cx0), .circ_cy(circ_cy0),
        .circ_r(circ_r0), .circ_colour(circ_colour0), .circ_x(8'd0), .circ_y(7'd0),
        .circ_colour_px(3'd0), .circ_plot(1'b0),
        .vga_x(vga_x0), .vga_y(vga_y0), .vga_colour(vga_colour0), .vga_plot(vga_plot0),
        .conflict(conflict0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t m;
        m.ph = P_IDLE;
        m.fs = 1'b0; m.cs = 1'b0; m.busy = 1'b0; m.done = 1'b0; m.conf = 1'b0; m.vp = 1'b0;
        m.cx = '0; m.r = '0; m.vx = '0; m.cy = '0; m.vy = '0; m.col = '0; m.vc = '0;
        return m;
    endfunction

    // One drawing request as a phase table; bus forwarded per the phase being entered.
    function automatic mdl_t mstep(input mdl_t m, input bit cf, input logic st,
                                   input logic fd, input logic fp, input logic [7:0] fx,
                                   input logic [6:0] fy, input logic [2:0] fc,
                                   input logic cd, input logic cp, input logic [7:0] cx,
                                   input logic [6:0] cy, input logic [2:0] cc);
        mdl_t n = m;
        int   np;
        case (m.ph)
            P_IDLE:  np = st ? (cf ? P_FILL : P_CIRC) : P_IDLE;
            P_FILL:  np = fd ? P_REL : P_FILL;
            P_REL:   np = fd ? P_REL : P_CIRC;
            P_CIRC:  np = cd ? P_DONE : P_CIRC;
            default: np = st ? P_DONE : P_IDLE;
        endcase
        if (m.ph == P_IDLE && st) begin
            n.cx = cfg_cx; n.cy = cfg_cy; n.r = cfg_r; n.col = cfg_colour;
        end
        n.ph   = np;
        n.fs   = (np == P_FILL);
        n.cs   = (np == P_CIRC);
        n.busy = (np >= P_FILL) && (np <= P_CIRC);
        n.done = (np == P_DONE);
        if (np == P_FILL) begin
            n.vx = fx; n.vy = fy; n.vc = fc; n.vp = fp;
        end else if (np == P_CIRC) begin
            n.vx = cx; n.vy = cy; n.vc = cc; n.vp = cp;
        end else begin
            n.vx = '0; n.vy = '0; n.vc = '0; n.vp = 1'b0;
        end
        n.conf = m.conf | (fp && np != P_FILL) | (cp && np != P_CIRC);
        return n;
    endfunction

    // Reference model, updated on the same events as the DUT registers.
    initial begin
        m1 = mreset();
        m0 = mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m1 = mreset();
                m0 = mreset();
            end else begin
                m1 = mstep(m1, 1'b1, start, fill_done, fill_plot, fill_x, fill_y, fill_colour,
                           circ_done, circ_plot, circ_x, circ_y, circ_colour_px);
                m0 = mstep(m0, 1'b0, start0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0,
                           circ_done0, 1'b0, 8'd0, 7'd0, 3'd0);
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("fill_start", 32'(fill_start), 32'(m1.fs));
            chk("circ_start", 32'(circ_start), 32'(m1.cs));
            chk("busy",       32'(busy),       32'(m1.busy));
            chk("done",       32'(done),       32'(m1.done));
            chk("circ_cx",    32'(circ_cx),    32'(m1.cx));
            chk("circ_cy",    32'(circ_cy),    32'(m1.cy));
            chk("circ_r",     32'(circ_r),     32'(m1.r));
            chk("circ_col",   32'(circ_colour), 32'(m1.col));
            chk("vga_x",      32'(vga_x),      32'(m1.vx));
            chk("vga_y",      32'(vga_y),      32'(m1.vy));
            chk("vga_col",    32'(vga_colour), 32'(m1.vc));
            chk("vga_plot",   32'(vga_plot),   32'(m1.vp));
            chk("conflict",   32'(conflict),   32'(m1.conf));
            chk("cf0_fill_start", 32'(fill_start0), 32'(m0.fs));
            chk("cf0_circ_start", 32'(circ_start0), 32'(m0.cs));
            chk("cf0_busy",       32'(busy0),       32'(m0.busy));
            chk("cf0_done",       32'(done0),       32'(m0.done));
            chk("cf0_circ_r",     32'(circ_r0),     32'(m0.r));
            chk("cf0_circ_cx",    32'(circ_cx0),    32'(m0.cx));
            chk("cf0_circ_cy",    32'(circ_cy0),    32'(m0.cy));
            chk("cf0_circ_col",   32'(circ_colour0), 32'(m0.col));
            chk("cf0_vga",        32'({vga_x0, vga_y0, vga_colour0, vga_plot0}), 32'(0));
            chk("cf0_conflict",   32'(conflict0),   32'(m0.conf));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) tick();
        chk("lit_reset_idle", 32'({fill_start, circ_start, busy, done, vga_plot, conflict}), 32'(0));
        rst_n = 1'b1;
        tick();

        // Run 1: full sequence, start held after completion.
        cfg_cx = 8'd80; cfg_cy = 7'd60; cfg_r = 8'd40; cfg_colour = 3'b010;
        start = 1'b1;
        tick();
        chk("lit_fill_start_rise", 32'(fill_start), 32'(1));
        chk("lit_busy_rise",       32'(busy),       32'(1));
        fill_x = 8'd0; fill_y = 7'd0; fill_colour = 3'b000; fill_plot = 1'b1;
        tick();
        chk("lit_vga_fill_plot0", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(1));
        fill_x = 8'd5; fill_y = 7'd7; fill_colour = 3'b101;
        circ_x = 8'd9; circ_y = 7'd3; circ_colour_px = 3'b111; circ_plot = 1'b1;
        cfg_r = 8'd5;
        tick();
        chk("lit_vga_fill_x", 32'(vga_x), 32'(5));
        chk("lit_vga_fill_y", 32'(vga_y), 32'(7));
        chk("lit_conflict_set", 32'(conflict), 32'(1));
        fill_plot = 1'b0; circ_plot = 1'b0; fill_done = 1'b1;
        tick();
        chk("lit_fill_start_drop", 32'(fill_start), 32'(0));
        tick();
        chk("lit_circ_wait_rel", 32'(circ_start), 32'(0));
        fill_done = 1'b0;
        tick();
        chk("lit_circ_start_rise", 32'(circ_start), 32'(1));
        chk("lit_circ_cx", 32'(circ_cx), 32'(80));
        chk("lit_circ_cy", 32'(circ_cy), 32'(60));
        chk("lit_circ_r_latched", 32'(circ_r), 32'(40));
        circ_x = 8'd78; circ_y = 7'd20; circ_colour_px = 3'b010; circ_plot = 1'b1;
        tick();
        chk("lit_vga_circ", 32'({vga_x, vga_y, vga_colour, vga_plot}),
            32'({8'd78, 7'd20, 3'b010, 1'b1}));
        circ_plot = 1'b0; circ_done = 1'b1;
        tick();
        chk("lit_done_rise", 32'(done), 32'(1));
        chk("lit_busy_fall", 32'(busy), 32'(0));
        circ_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("lit_done_held", 32'(done), 32'(1));
        end
        start = 1'b0;
        tick();
        chk("lit_done_fall", 32'(done), 32'(0));
        chk("lit_conflict_idle", 32'(conflict), 32'(1));

        // Run 2: start pulsed, cfg changed after latch, start low at completion.
        start = 1'b1;
        tick();
        start = 1'b0; cfg_r = 8'd33;
        tick();
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        tick();
        chk("lit_run2_circ_r", 32'(circ_r), 32'(5));
        circ_done = 1'b1;
        tick();
        chk("lit_run2_done", 32'(done), 32'(1));
        circ_done = 1'b0;
        tick();
        chk("lit_run2_done_1cyc", 32'(done), 32'(0));

        // CLEAR_FIRST=0 instance goes straight to circle.
        start0 = 1'b1;
        tick();
        chk("lit_cf0_circ_start", 32'({fill_start0, circ_start0}), 32'(1));
        start0 = 1'b0;
        repeat (3) tick();
        circ_done0 = 1'b1;
        tick();
        chk("lit_cf0_done", 32'(done0), 32'(1));
        circ_done0 = 1'b0;
        tick();

        // Asynchronous reset in the middle of a fill with a pixel in flight.
        start = 1'b1;
        tick();
        fill_x = 8'd1; fill_y = 7'd2; fill_colour = 3'd3; fill_plot = 1'b1;
        tick();
        chk("lit_pre_reset_plot", 32'(vga_plot), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("lit_async_ctrl", 32'({fill_start, circ_start, busy, done, conflict}), 32'(0));
        chk("lit_async_bus", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(0));
        chk("lit_async_cfg", 32'({circ_cx, circ_cy, circ_r, circ_colour}), 32'(0));
        tick();
        start = 1'b0; fill_plot = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("lit_post_reset_idle", 32'({fill_start, busy, conflict}), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
